// File: rtl/ma_stage_hs_if.sv
// Handshake bundle for ma_stage_hs: EX-side request, WB-side result and data-memory port.
// The stage itself connects through the slave modport; the environment uses master.
interface ma_stage_hs_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 22
);
    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     in_pc;
    logic [XLEN-1:0]     in_alu;
    logic [XLEN-1:0]     in_op2;
    logic [31:0]         in_ir;
    logic [CTRL_W-1:0]   in_ctrl;

    logic                mem_req;
    logic                mem_we;
    logic [XLEN-1:0]     mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN/8-1:0]   mem_be;
    logic                mem_ack;
    logic [XLEN-1:0]     mem_rdata;

    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic [XLEN-1:0]     out_alu;
    logic [31:0]         out_ir;
    logic [CTRL_W-1:0]   out_ctrl;
    logic [XLEN-1:0]     out_ld_result;
    logic [1:0]          out_err;

    modport slave (
        input  in_valid, in_pc, in_alu, in_op2, in_ir, in_ctrl,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata,
        output out_valid, out_pc, out_alu, out_ir, out_ctrl, out_ld_result, out_err,
        input  out_ready
    );

    modport master (
        output in_valid, in_pc, in_alu, in_op2, in_ir, in_ctrl,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata,
        input  out_valid, out_pc, out_alu, out_ir, out_ctrl, out_ld_result, out_err,
        output out_ready
    );
endinterface

// File: rtl/ma_stage_hs.sv
// Registered memory-access stage between EX and WB with a req/ack data-memory port.
// Optional bus timeout is enabled by defining MA_TIMEOUT_EN.
module ma_stage_hs #(
    parameter int XLEN     = 32,
    parameter int CTRL_W   = 22,
    parameter int MAX_WAIT = 15
) (
    input logic            clk,
    input logic            rst_n,
    ma_stage_hs_if.slave   bus
);
    localparam int NB     = XLEN / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
`ifdef MA_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e              state_q;
    logic                out_valid_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [XLEN-1:0]     mem_addr_q;
    logic [XLEN-1:0]     mem_wdata_q;
    logic [NB-1:0]       mem_be_q;
    logic [XLEN-1:0]     out_pc_q;
    logic [XLEN-1:0]     out_alu_q;
    logic [31:0]         out_ir_q;
    logic [CTRL_W-1:0]   out_ctrl_q;
    logic [XLEN-1:0]     out_ld_q;
    logic [1:0]          out_err_q;
    logic [WAIT_W-1:0]   wait_q;

    logic                in_ready;
    logic                accept;
    logic                in_mem;
    logic                misaligned;
    logic [OFF_W-1:0]    in_off;
    logic [NB-1:0]       be_d;
    logic [XLEN-1:0]     wdata_d;
    logic                out_is_load;
    logic [XLEN-1:0]     lane;
    logic [XLEN-1:0]     lane_top;
    logic [XLEN-1:0]     ld_sext;
    logic [XLEN-1:0]     ld_zext;
    logic [XLEN-1:0]     ld_ext;
    logic [6:0]          shamt;
    logic                timeout_hit;

    assign in_ready    = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept      = bus.in_valid && in_ready;
    assign in_mem      = |bus.in_ctrl[1:0];
    assign in_off      = bus.in_alu[OFF_W-1:0];
    assign out_is_load = out_ctrl_q[1] && !out_ctrl_q[0];
    assign timeout_hit = TIMEOUT_EN && (wait_q == WAIT_LAST);

    always_comb begin
        misaligned = 1'b0;
        be_d       = '1;
        wdata_d    = bus.in_op2;
        case (bus.in_ctrl[3:2])
            2'b00: begin
                be_d    = NB'(1) << in_off;
                wdata_d = {(XLEN/8){bus.in_op2[7:0]}};
            end
            2'b01: begin
                misaligned = bus.in_alu[0];
                be_d       = NB'(3) << in_off;
                wdata_d    = {(XLEN/16){bus.in_op2[15:0]}};
            end
            2'b10: begin
                misaligned = |bus.in_alu[1:0];
                be_d       = NB'(4'hF) << in_off;
                wdata_d    = {(XLEN/32){bus.in_op2[31:0]}};
            end
            default: begin
                misaligned = (XLEN == 32) || (|bus.in_alu[2:0]);
            end
        endcase
    end

    // Extension works by pushing the selected field to the top of the word and shifting it back down.
    always_comb begin
        shamt = 7'd0;
        case (out_ctrl_q[3:2])
            2'b00:   shamt = 7'(XLEN - 8);
            2'b01:   shamt = 7'(XLEN - 16);
            2'b10:   shamt = 7'(XLEN - 32);
            default: shamt = 7'd0;
        endcase
        lane     = bus.mem_rdata >> {out_alu_q[OFF_W-1:0], 3'b000};
        lane_top = lane << shamt;
        ld_sext  = $signed(lane_top) >>> shamt;
        ld_zext  = lane_top >> shamt;
        ld_ext   = out_ctrl_q[4] ? ld_zext : ld_sext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            out_pc_q    <= '0;
            out_alu_q   <= '0;
            out_ir_q    <= '0;
            out_ctrl_q  <= '0;
            out_ld_q    <= '0;
            out_err_q   <= '0;
            wait_q      <= '0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        out_pc_q   <= bus.in_pc;
                        out_alu_q  <= bus.in_alu;
                        out_ir_q   <= bus.in_ir;
                        out_ctrl_q <= bus.in_ctrl;
                        out_ld_q   <= '0;
                        wait_q     <= '0;
                        if (!in_mem) begin
                            out_err_q   <= 2'b00;
                            out_valid_q <= 1'b1;
                        end else if (misaligned) begin
                            out_err_q   <= 2'b01;
                            out_valid_q <= 1'b1;
                        end else begin
                            out_err_q   <= 2'b00;
                            state_q     <= ACCESS;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.in_ctrl[0];
                            mem_addr_q  <= {bus.in_alu[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata_q <= wdata_d;
                            mem_be_q    <= be_d;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= '0;
                        out_valid_q <= 1'b1;
                        out_ld_q    <= out_is_load ? ld_ext : '0;
                    end else if (timeout_hit) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= '0;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 2'b10;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_be        = mem_be_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_pc        = out_pc_q;
    assign bus.out_alu       = out_alu_q;
    assign bus.out_ir        = out_ir_q;
    assign bus.out_ctrl      = out_ctrl_q;
    assign bus.out_ld_result = out_ld_q;
    assign bus.out_err       = out_err_q;
endmodule

// File: tb/tb_ma_stage_hs.sv
// Scoreboard bench for ma_stage_hs (XLEN=32): stimulus pushes expected WB results, a monitor pops them.
// The timeout scenario runs only when MA_TIMEOUT_EN is defined.
module tb_ma_stage_hs;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] ir;
        logic [21:0] ctrl;
        logic [31:0] ld;
        logic [1:0]  err;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    nCompared = 0;
    int    nMismatched = 0;
    exp_t  expQ[$];
    logic [31:0] pcNext = 32'h0000_1000;

    ma_stage_hs_if #(.XLEN(32), .CTRL_W(22)) bus ();

    ma_stage_hs #(.XLEN(32), .CTRL_W(22), .MAX_WAIT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every WB handshake must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_out_valid", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_pc", bus.out_pc, e.pc);
                    checkOutput("out_alu", bus.out_alu, e.alu);
                    checkOutput("out_ir", bus.out_ir, e.ir);
                    checkOutput("out_ctrl", bus.out_ctrl, e.ctrl);
                    checkOutput("out_ld_result", bus.out_ld_result, e.ld);
                    checkOutput("out_err", bus.out_err, e.err);
                end
            end
        end
    end

    task automatic driveOp(input logic [31:0] alu, input logic [31:0] op2, input logic [21:0] ctrl,
                           input logic [31:0] expLd, input logic [1:0] expErr);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_pc    = pcNext;
        bus.in_alu   = alu;
        bus.in_op2   = op2;
        bus.in_ir    = pcNext ^ 32'h0000_0013;
        bus.in_ctrl  = ctrl;
        e.pc = pcNext; e.alu = alu; e.ir = pcNext ^ 32'h0000_0013;
        e.ctrl = ctrl; e.ld = expLd; e.err = expErr;
        expQ.push_back(e);
        pcNext = pcNext + 32'd4;
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] alu, input logic [31:0] op2,
                                 input logic [21:0] ctrl, input logic [31:0] rdata, input int waits,
                                 input bit expReq, input logic [31:0] expLd, input logic [1:0] expErr,
                                 input logic [31:0] expAddr, input logic expWe, input logic [3:0] expBe,
                                 input logic [31:0] expWdata, input int expLat);
        int guard = 0;
        int cycles;
        while (!bus.in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (guard == 50) checkOutput({name, "_in_ready_wait"}, 0, 1);
        driveOp(alu, op2, ctrl, expLd, expErr);
        step();
        bus.in_valid = 1'b0;
        cycles = 1;
        if (expReq) begin
            checkOutput({name, "_mem_req"}, bus.mem_req, 1);
            checkOutput({name, "_mem_addr"}, bus.mem_addr, expAddr);
            checkOutput({name, "_mem_we"}, bus.mem_we, expWe);
            checkOutput({name, "_mem_be"}, bus.mem_be, expBe);
            if (expWe) checkOutput({name, "_mem_wdata"}, bus.mem_wdata, expWdata);
            repeat (waits) begin
                step();
                cycles++;
            end
            checkOutput({name, "_req_held"}, {bus.mem_req, bus.mem_be, bus.mem_addr}, {1'b1, expBe, expAddr});
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rdata;
            step();
            cycles++;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h0;
        end else begin
            checkOutput({name, "_no_mem_req"}, bus.mem_req, 0);
        end
        while (!bus.out_valid && cycles < 40) begin
            step();
            cycles++;
        end
        checkOutput({name, "_latency"}, cycles, expLat);
        checkOutput({name, "_req_dropped"}, bus.mem_req, 0);
    endtask

    initial begin
        logic [31:0] heldAlu;
        int cnt;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = 32'h0;
        bus.in_alu    = 32'h0;
        bus.in_op2    = 32'h0;
        bus.in_ir     = 32'h0;
        bus.in_ctrl   = 22'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_mem_req", bus.mem_req, 0);
        checkOutput("rst_mem_we_be", {bus.mem_we, bus.mem_be}, 0);
        checkOutput("rst_out_err", bus.out_err, 0);
        checkOutput("rst_data", {bus.out_alu, bus.out_ld_result}, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", bus.in_ready, 1);
        step();

        //            name       alu           op2           ctrl    rdata         w  req ld            err    addr          we    be       wdata         lat
        applyStimulus("alu",     32'h1234,     32'h0,        22'h00, 32'h0,        0, 0,  32'h0,        2'b00, 32'h0,        1'b0, 4'b0000, 32'h0,        1);
        applyStimulus("lb_s",    32'h103,      32'h0,        22'h02, 32'h80FF_FF00,3, 1,  32'hFFFF_FF80,2'b00, 32'h100,      1'b0, 4'b1000, 32'h0,        5);
        applyStimulus("sh",      32'h202,      32'hDEAD_BEEF,22'h05, 32'h1234_5678,1, 1,  32'h0,        2'b00, 32'h200,      1'b1, 4'b1100, 32'hBEEF_BEEF,3);
        applyStimulus("lw_mis",  32'h101,      32'h0,        22'h0A, 32'h0,        0, 0,  32'h0,        2'b01, 32'h0,        1'b0, 4'b0000, 32'h0,        1);
        applyStimulus("lbu",     32'h102,      32'h0,        22'h12, 32'h80FF_FF00,0, 1,  32'h0000_00FF,2'b00, 32'h100,      1'b0, 4'b0100, 32'h0,        2);
        applyStimulus("lh_s",    32'h206,      32'h0,        22'h06, 32'h8001_7FFF,2, 1,  32'hFFFF_8001,2'b00, 32'h204,      1'b0, 4'b1100, 32'h0,        4);
        applyStimulus("lw",      32'h208,      32'h0,        22'h0A, 32'hCAFE_F00D,0, 1,  32'hCAFE_F00D,2'b00, 32'h208,      1'b0, 4'b1111, 32'h0,        2);
        applyStimulus("ld_rv32", 32'h210,      32'h0,        22'h0E, 32'h0,        0, 0,  32'h0,        2'b01, 32'h0,        1'b0, 4'b0000, 32'h0,        1);
        applyStimulus("ldst",    32'h20C,      32'h1122_3344,22'h0B, 32'hFFFF_FFFF,1, 1,  32'h0,        2'b00, 32'h20C,      1'b1, 4'b1111, 32'h1122_3344,3);
        applyStimulus("sh_mis",  32'h201,      32'h0,        22'h05, 32'h0,        0, 0,  32'h0,        2'b01, 32'h0,        1'b0, 4'b0000, 32'h0,        1);
        applyStimulus("sb",      32'h001,      32'h0000_00A5,22'h01, 32'h0,        0, 1,  32'h0,        2'b00, 32'h000,      1'b1, 4'b0010, 32'hA5A5_A5A5,2);

        // Back-to-back ALU ops with a stray mem_ack that must be ignored.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_DEAD;
        for (int k = 0; k < 3; k++) begin
            driveOp(32'h5000 + 32'(k), 32'h0, 22'h00, 32'h0, 2'b00);
            #1;
            checkOutput("thru_in_ready", bus.in_ready, 1);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        checkOutput("thru_no_mem_req", bus.mem_req, 0);
        step();

        // Backpressure: result held, then released in the same cycle a new op is taken.
        bus.out_ready = 1'b0;
        applyStimulus("hold", 32'hAAAA, 32'h0, 22'h00, 32'h0, 0, 0, 32'h0, 2'b00, 32'h0, 1'b0, 4'b0000, 32'h0, 1);
        heldAlu = bus.out_alu;
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput("hold_stable", {bus.out_valid, bus.out_alu, bus.out_err}, {1'b1, 32'hAAAA, 2'b00});
            checkOutput("hold_in_ready", bus.in_ready, 0);
        end
        driveOp(32'hBBBB, 32'h0, 22'h00, 32'h0, 2'b00);
        step();
        checkOutput("hold_not_taken", bus.out_alu, heldAlu);
        bus.out_ready = 1'b1;
        #1;
        checkOutput("release_in_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        checkOutput("release_taken", {bus.out_valid, bus.out_alu}, {1'b1, 32'hBBBB});
        step();

`ifdef MA_TIMEOUT_EN
        driveOp(32'h400, 32'h0, 22'h0A, 32'h0, 2'b10);
        step();
        bus.in_valid = 1'b0;
        cnt = 0;
        while (bus.mem_req && cnt < 40) begin
            cnt++;
            step();
        end
        checkOutput("timeout_req_cycles", cnt, 15);
        checkOutput("timeout_valid", bus.out_valid, 1);
        step();
`endif

        cnt = 0;
        while (expQ.size() != 0 && cnt < 50) begin
            step();
            cnt++;
        end
        checkOutput("scoreboard_drained", expQ.size(), 0);

        // Reset in the middle of an access abandons it.
        bus.in_valid = 1'b1;
        bus.in_alu   = 32'h500;
        bus.in_ctrl  = 22'h0A;
        step();
        bus.in_valid = 1'b0;
        checkOutput("midrst_req_before", bus.mem_req, 1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_req_async", bus.mem_req, 0);
        checkOutput("midrst_out_valid", bus.out_valid, 0);
        step();
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_in_ready", bus.in_ready, 1);
        repeat (3) step();
        checkOutput("midrst_abandoned", {bus.out_valid, bus.mem_req}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/ma_stage_hs.md
# ma_stage_hs

Parametrised, registered memory-access pipeline stage with valid/ready flow control. It sits between the EX and WB stages. It forwards PC, ALU result, IR and control bus to WB, and performs loads and stores over a req/ack data-memory port with wait states. It also provides byte-enable generation, load sign/zero extension and misalignment detection.

## Interface
- `XLEN`, 32: datapath width; legal values 32 or 64.
- `CTRL_W`, 22: control bus width.
- `MAX_WAIT`, 15: cycles allowed for `mem_ack`; used only with `MA_TIMEOUT_EN`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: EX presents an instruction.
- `in_ready` out 1: stage accepts the instruction this cycle.
- `in_pc`, `in_alu`, `in_op2` in XLEN: PC, effective address/ALU result, store data.
- `in_ir` in 32: instruction word.
- `in_ctrl` in CTRL_W: control bus fields:
  - [0] store; [1] load.
  - [3:2] size: 00 byte, 01 half, 10 word, 11 double (legal only when XLEN=64).
  - [4] unsigned load.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write strobe, qualified by `mem_req`.
- `mem_addr` out XLEN: address, low bits aligned down to XLEN/8.
- `mem_wdata` out XLEN: lane-replicated store data.
- `mem_be` out XLEN/8: byte enables.
- `mem_ack` in 1: request completed; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in XLEN: read data.
- `out_valid` out 1: result valid to WB.
- `out_ready` in 1: WB accepts the result.
- `out_pc`, `out_alu` out XLEN; `out_ir` out 32; `out_ctrl` out CTRL_W: registered copies of the inputs.
- `out_ld_result` out XLEN: extended load data; 0 for non-loads.
- `out_err` out 2: [0] misaligned access; [1] bus timeout.

## Operation
- States: IDLE, ACCESS.
- `in_ready` = IDLE && (!`out_valid` || `out_ready`).
- Accept happens when `in_valid` && `in_ready`. On accept, all `in_*` are latched.
- Accept of a non-memory op (ctrl[1:0]=00): result registered; `out_valid`=1 next cycle; state stays IDLE.
- Alignment of a memory op:
  - Misaligned if the address is not a multiple of the size in bytes.
  - Size 11 with XLEN=32 counts as misaligned.
  - On misalignment: no memory request; `out_valid` next cycle; `out_err[0]`=1; `out_ld_result`=0.
- Accept of an aligned memory op:
  - Go to ACCESS.
  - `mem_req`=1 from the next cycle, held with stable address/data/be until `mem_ack`.
  - On the `mem_ack` cycle: capture extended `mem_rdata`, drop `mem_req`, return to IDLE. `out_valid`=1 on the following edge.
- Load and store both set (ctrl[1:0]=11): handled as a store.
- Store lane generation, with `o` = addr mod XLEN/8:
  - Byte: data[7:0] replicated on all lanes; `mem_be` = 1<<o.
  - Half: data[15:0] replicated; `mem_be` = 2'b11<<o.
  - Word: data[31:0] replicated; `mem_be` = 4'hF<<o.
  - Double: all ones.
- Load extraction:
  - Select the lane at `o`.
  - Sign-extend to XLEN unless ctrl[4]=1, in which case zero-extend.
  - Word loads with XLEN=32 pass through unchanged.
- Output hold: `out_*` and `out_err` stay stable while `out_valid` && !`out_ready`. `out_valid` clears after a handshake with no new result pending.

## Timing
- Reset values (async on `rst_n` low):
  - State IDLE.
  - `out_valid`, `mem_req`, `mem_we`, `mem_be`, `out_err` = 0.
  - All data outputs = 0.
  - `in_ready` = 1 after reset release.
- Latency, accept edge to `out_valid`:
  - Non-memory or misaligned op: 1 cycle.
  - Memory op: 2 + N cycles, where N = wait cycles before `mem_ack`. With ack in the first request cycle, `out_valid` rises 2 edges after accept.
- Throughput: one non-memory op per cycle when `out_ready`=1 continuously. `in_ready` is 0 throughout ACCESS.
- `mem_ack` outside ACCESS is ignored.
- Reset mid-ACCESS: `mem_req` drops immediately and the transaction is abandoned.

## Configuration
- `MA_TIMEOUT_EN` defined:
  - A counter runs during ACCESS.
  - If `mem_ack` is absent for `MAX_WAIT` consecutive request cycles: drop `mem_req`, return to IDLE, output with `out_err[1]`=1 and `out_ld_result`=0.
  - A store counts as not performed.
- `MA_TIMEOUT_EN` undefined: ACCESS waits indefinitely; `out_err[1]` is tied to 0.

## Test plan
- ALU op, `in_alu`=0x1234, `out_ready`=1 -> `out_valid` next cycle, `out_alu`=0x1234, `mem_req` never 1.
- Byte load, addr 0x103, signed, `mem_rdata`=0x80FF_FF00, ack after 3 waits -> `mem_addr`=0x100, `out_ld_result`=0xFFFF_FF80, `out_valid` 5 cycles after accept.
- Half store, addr 0x202, `in_op2`=0xDEAD_BEEF -> `mem_we`=1, `mem_be`=4'b1100, `mem_wdata`=0xBEEF_BEEF.
- Word load at addr 0x101 -> no `mem_req`, `out_err`=2'b01, `out_ld_result`=0, latency 1.
- Result held with `out_ready`=0 for 4 cycles -> outputs stable, `in_ready`=0; releasing `out_ready` accepts the next op in the same cycle.
- With `MA_TIMEOUT_EN` and `MAX_WAIT`=15, load with `mem_ack` tied 0 -> `mem_req` high for exactly 15 cycles, then `out_err`=2'b10. Asserting `rst_n`=0 mid-ACCESS clears `mem_req` asynchronously.
